// File: rtl/td4_pkg.sv
// td4_pkg: state and speed encodings shared by the TD4 run controller.
package td4_pkg;

    // Sequencer states. The encoding is visible on the state output.
    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } run_state_t;

    // speed_sel codes. Both 2'b10 and 2'b11 select full speed.
    localparam logic [1:0] SPD_SLOW = 2'b00;
    localparam logic [1:0] SPD_FAST = 2'b01;
    localparam logic [1:0] SPD_FULL = 2'b10;

    // Full speed: an enable on every clock, with no prescaling.
    function automatic logic is_full_speed(input logic [1:0] sel);
        return sel[1];
    endfunction

endpackage

// File: rtl/td4_run_ctrl_if.sv
// td4_run_ctrl_if: control pulses, breakpoint inputs and status outputs of the run controller.
interface td4_run_ctrl_if #(
    parameter int CYC_W = 16
);
    logic             start_i;
    logic             stop_i;
    logic             step_i;
    logic [1:0]       speed_sel;
    logic [3:0]       pc;
    logic [3:0]       bp_addr;
    logic             bp_valid;
    logic             cnt_clr;
    logic             EN;
    logic [1:0]       state;
    logic             halted;
    logic             bp_hit;
    logic [CYC_W-1:0] cycle_cnt;

    // Board side: drives the controls and observes the sequencer.
    modport master (
        output start_i, stop_i, step_i, speed_sel, pc, bp_addr, bp_valid, cnt_clr,
        input  EN, state, halted, bp_hit, cycle_cnt
    );

    // Sequencer side.
    modport slave (
        input  start_i, stop_i, step_i, speed_sel, pc, bp_addr, bp_valid, cnt_clr,
        output EN, state, halted, bp_hit, cycle_cnt
    );
endinterface

// File: rtl/td4_tick_gen.sv
// td4_tick_gen: prescaler that emulates the board's 1 Hz / 10 Hz / manual clock switch.
// tick marks the cycle in which an enable is due. clear flags a speed_sel change; the caller
// must suppress tick in that cycle.
module td4_tick_gen
    import td4_pkg::*;
#(
    parameter int PRESCALE_W = 24,
    parameter int DIV_SLOW   = 12000000,
    parameter int DIV_FAST   = 1200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [1:0] speed_sel,
    output logic       tick,
    output logic       clear
);

    localparam logic [PRESCALE_W-1:0] SLOW_M1 = PRESCALE_W'(DIV_SLOW - 1);
    localparam logic [PRESCALE_W-1:0] FAST_M1 = PRESCALE_W'(DIV_FAST - 1);

    logic [PRESCALE_W-1:0] presc_q;
    logic [PRESCALE_W-1:0] div_m1;
    logic [1:0]            speed_q;

    assign div_m1 = (speed_sel == SPD_SLOW) ? SLOW_M1 : FAST_M1;
    assign clear  = (speed_sel != speed_q);
    assign tick   = is_full_speed(speed_sel) || (presc_q == div_m1);

    // Count only while running. The count restarts outside RUN and after a speed change, so the
    // first enable lands a full period after either event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            speed_q <= SPD_SLOW;
        end else begin
            speed_q <= speed_sel;
            if (!run || clear) begin
                presc_q <= '0;
            end else if (presc_q == div_m1) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/td4_run_ctrl.sv
// td4_run_ctrl: run/halt/single-step sequencer for the TD4 core. It drives the shared register
// enable EN and counts the instructions executed.
// Build option TD4_BREAKPOINT_EN: when defined, the core halts into BREAK when the PC matches
// bp_addr. When undefined, the breakpoint inputs are ignored and BREAK is never entered.
module td4_run_ctrl
    import td4_pkg::*;
#(
    parameter int PRESCALE_W = 24,
    parameter int DIV_SLOW   = 12000000,
    parameter int DIV_FAST   = 1200000,
    parameter int CYC_W      = 16
) (
    input  logic          CLK,
    input  logic          CLR,
    td4_run_ctrl_if.slave bus
);

    run_state_t       state_q;
    logic             halted_q;
    logic [CYC_W-1:0] cnt_q;
    logic             tick_raw;
    logic             spd_clear;
    logic             tick;
    logic             bp_stop;
    logic             en;

    td4_tick_gen #(
        .PRESCALE_W (PRESCALE_W),
        .DIV_SLOW   (DIV_SLOW),
        .DIV_FAST   (DIV_FAST)
    ) u_tick_gen (
        .clk       (CLK),
        .rst_n     (CLR),
        .run       (state_q == ST_RUN),
        .speed_sel (bus.speed_sel),
        .tick      (tick_raw),
        .clear     (spd_clear)
    );

    assign tick = tick_raw && !spd_clear;

`ifdef TD4_BREAKPOINT_EN
    logic skip_q;
    logic bp_hit_q;
    logic enter_break;
    logic resume;

    assign bp_stop     = bus.bp_valid && (bus.pc == bus.bp_addr) && tick && !skip_q;
    assign enter_break = (state_q == ST_RUN) && !bus.stop_i && bp_stop;
    assign resume      = (state_q == ST_BREAK) && !bus.stop_i && (bus.step_i || bus.start_i);

    // bp_hit follows BREAK exactly. skip lets the breakpointed instruction execute once on resume.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            skip_q   <= 1'b0;
            bp_hit_q <= 1'b0;
        end else begin
            bp_hit_q <= enter_break ||
                        ((state_q == ST_BREAK) && !(bus.stop_i || bus.step_i || bus.start_i));
            if (resume) begin
                skip_q <= 1'b1;
            end else if (en) begin
                skip_q <= 1'b0;
            end
        end
    end

    assign bus.bp_hit = bp_hit_q;
`else
    logic unused_bp_inputs;

    assign unused_bp_inputs = ^{bus.pc, bus.bp_addr, bus.bp_valid};
    assign bp_stop          = 1'b0;
    assign bus.bp_hit       = 1'b0;
`endif

    assign en = ((state_q == ST_RUN) && tick && !bp_stop) || (state_q == ST_STEP);

    // Sequencer: stop beats step, and step beats start. STEP lasts one cycle only.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
        end else begin
            case (state_q)
                ST_HALT, ST_BREAK: begin
                    if (bus.stop_i) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else if (bus.step_i) begin
                        state_q  <= ST_STEP;
                        halted_q <= 1'b0;
                    end else if (bus.start_i) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bus.stop_i) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else if (bp_stop) begin
                        state_q  <= ST_BREAK;
                        halted_q <= 1'b1;
                    end
                end
                ST_STEP: begin
                    state_q  <= ST_HALT;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_HALT;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    // Instruction counter: saturates at all-ones. A clear overrides an increment in the same cycle.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CYC_W'(1);
        end
    end

    assign bus.EN        = en;
    assign bus.state     = state_q;
    assign bus.halted    = halted_q;
    assign bus.cycle_cnt = cnt_q;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// tb_td4_run_ctrl: scoreboard bench for td4_run_ctrl (DIV_SLOW=8, DIV_FAST=4, CYC_W=4).
// A cycle-level reference model pushes the expected outputs for each cycle. A negedge monitor
// pops each entry and compares it with the DUT. The bench PC advances by one on every expected
// enable.
module tb_td4_run_ctrl;

`ifdef TD4_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    localparam int CNT_MAX = 15;

    typedef struct {
        logic [1:0] st;
        logic       en;
        logic       halted;
        logic       bp_hit;
        logic [3:0] cnt;
    } exp_t;

    logic CLK;
    logic CLR;

    td4_run_ctrl_if #(.CYC_W(4)) bus();

    td4_run_ctrl #(
        .PRESCALE_W (24),
        .DIV_SLOW   (8),
        .DIV_FAST   (4),
        .CYC_W      (4)
    ) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    bit   mon_en   = 1'b0;

    // Model state, using the spec encoding 0 HALT, 1 RUN, 2 STEP, 3 BREAK.
    int         m_st;
    int         m_e;
    logic [1:0] m_prev_spd;
    bit         m_skip;
    int         m_cnt;
    logic [3:0] m_pc;

    // Inputs applied for the current cycle.
    bit         in_start, in_stop, in_step, in_cnt_clr, in_bp_valid;
    logic [1:0] in_speed;
    logic [3:0] in_bp_addr;

    // Requests picked up at the next cycle boundary.
    bit         nb_valid;
    logic [3:0] nb_addr;
    bit         req_pc_zero;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Combinational view of the model for the current cycle.
    function automatic void model_eval(output bit tick, output bit bpstop, output bit en);
        bit chg;
        bit full;
        int div;
        chg    = (in_speed != m_prev_spd);
        full   = in_speed[1];
        div    = (in_speed == 2'b00) ? 8 : 4;
        tick   = !chg && (full || ((m_e % div) == div - 1));
        bpstop = BP_EN && in_bp_valid && (m_pc == in_bp_addr) && tick && !m_skip;
        en     = ((m_st == 1) && tick && !bpstop) || (m_st == 2);
    endfunction

    // Advance the model by one clock, using the inputs applied during the cycle that just ended.
    function automatic void model_advance();
        bit tk, bs, en;
        int nxt;
        model_eval(tk, bs, en);
        nxt = m_st;
        case (m_st)
            0, 3: begin
                if (in_stop)       nxt = 0;
                else if (in_step)  nxt = 2;
                else if (in_start) nxt = 1;
            end
            1: begin
                if (in_stop)       nxt = 0;
                else if (bs)       nxt = 3;
            end
            default: nxt = 0;
        endcase
        if ((m_st == 3) && ((nxt == 1) || (nxt == 2))) m_skip = 1'b1;
        else if (en) m_skip = 1'b0;
        if (in_cnt_clr)                m_cnt = 0;
        else if (en && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        if ((m_st != 1) || (in_speed != m_prev_spd)) m_e = 0;
        else m_e = m_e + 1;
        if (en) m_pc = m_pc + 4'd1;
        m_prev_spd = in_speed;
        m_st       = nxt;
    endfunction

    task automatic applyStimulus(input bit s, input bit p, input bit t, input logic [1:0] spd,
                                 input bit cc);
        exp_t e;
        bit tk, bs, en;
        @(posedge CLK);
        #1;
        model_advance();
        if (req_pc_zero) begin
            m_pc        = 4'd0;
            req_pc_zero = 1'b0;
        end
        in_start    = s;
        in_stop     = p;
        in_step     = t;
        in_speed    = spd;
        in_cnt_clr  = cc;
        in_bp_valid = nb_valid;
        in_bp_addr  = nb_addr;
        bus.start_i   = s;
        bus.stop_i    = p;
        bus.step_i    = t;
        bus.speed_sel = spd;
        bus.cnt_clr   = cc;
        bus.bp_valid  = nb_valid;
        bus.bp_addr   = nb_addr;
        bus.pc        = m_pc;
        model_eval(tk, bs, en);
        e.st     = 2'(m_st);
        e.en     = en;
        e.halted = (m_st == 0) || (m_st == 3);
        e.bp_hit = (m_st == 3);
        e.cnt    = 4'(m_cnt);
        exp_q.push_back(e);
        mon_en = 1'b1;
    endtask

    // Assert CLR between clock edges, check that it takes effect at once, then release it.
    task automatic doReset();
        mon_en = 1'b0;
        @(posedge CLK);
        #3;
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        bus.step_i  = 1'b0;
        bus.cnt_clr = 1'b0;
        CLR = 1'b0;
        #1;
        checkOutput("rst_state", bus.state, 0);
        checkOutput("rst_en", bus.EN, 0);
        checkOutput("rst_halted", bus.halted, 1);
        checkOutput("rst_cnt", bus.cycle_cnt, 0);
        checkOutput("rst_bp_hit", bus.bp_hit, 0);
        repeat (2) begin
            @(negedge CLK);
            checkOutput("rst_en_hold", bus.EN, 0);
        end
        @(posedge CLK);
        #3;
        CLR = 1'b1;
        exp_q.delete();
        m_st       = 0;
        m_e        = 0;
        m_prev_spd = 2'b00;
        m_skip     = 1'b0;
        m_cnt      = 0;
        in_start   = 1'b0;
        in_stop    = 1'b0;
        in_step    = 1'b0;
        in_cnt_clr = 1'b0;
    endtask

    // Monitor: compare each cycle's DUT outputs with the oldest expected entry.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1 (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("state", bus.state, mon_e.st);
                checkOutput("EN", bus.EN, mon_e.en);
                checkOutput("halted", bus.halted, mon_e.halted);
                checkOutput("bp_hit", bus.bp_hit, mon_e.bp_hit);
                checkOutput("cycle_cnt", bus.cycle_cnt, mon_e.cnt);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] spd;
        CLR           = 1'b0;
        bus.start_i   = 1'b0;
        bus.stop_i    = 1'b0;
        bus.step_i    = 1'b0;
        bus.speed_sel = 2'b00;
        bus.cnt_clr   = 1'b0;
        bus.bp_valid  = 1'b0;
        bus.bp_addr   = 4'd0;
        bus.pc        = 4'd0;
        m_pc          = 4'd0;
        in_speed      = 2'b00;
        in_bp_valid   = 1'b0;
        in_bp_addr    = 4'd0;
        nb_valid      = 1'b0;
        nb_addr       = 4'd0;
        req_pc_zero   = 1'b0;
        doReset();

        $display("[TB] full speed run/stop");
        repeat (2) applyStimulus(0, 0, 0, 2'b10, 0);
        applyStimulus(1, 0, 0, 2'b10, 0);
        repeat (3) applyStimulus(0, 0, 0, 2'b10, 0);
        applyStimulus(0, 1, 0, 2'b10, 0);
        applyStimulus(0, 0, 0, 2'b10, 0);
        checkOutput("run_stop_state", bus.state, 0);
        checkOutput("run_stop_cnt", bus.cycle_cnt, 4);

        $display("[TB] single step");
        applyStimulus(0, 0, 1, 2'b10, 0);
        applyStimulus(0, 0, 0, 2'b10, 0);
        checkOutput("step_state", bus.state, 2);
        applyStimulus(0, 0, 0, 2'b10, 0);
        checkOutput("step_back_state", bus.state, 0);
        checkOutput("step_cnt", bus.cycle_cnt, 5);

        $display("[TB] fast run, then switch to slow");
        applyStimulus(0, 0, 0, 2'b01, 0);
        applyStimulus(1, 0, 0, 2'b01, 0);
        repeat (10) applyStimulus(0, 0, 0, 2'b01, 0);
        repeat (14) applyStimulus(0, 0, 0, 2'b00, 0);
        applyStimulus(0, 1, 0, 2'b00, 0);
        applyStimulus(0, 0, 0, 2'b00, 0);

        $display("[TB] breakpoint at pc=3");
        req_pc_zero = 1'b1;
        nb_valid    = 1'b1;
        nb_addr     = 4'd3;
        applyStimulus(0, 0, 0, 2'b10, 0);
        applyStimulus(1, 0, 0, 2'b10, 0);
        repeat (5) applyStimulus(0, 0, 0, 2'b10, 0);
        applyStimulus(1, 0, 0, 2'b10, 0);
        repeat (3) applyStimulus(0, 0, 0, 2'b10, 0);
        applyStimulus(0, 1, 0, 2'b10, 0);
        nb_valid = 1'b0;
        applyStimulus(0, 0, 0, 2'b10, 0);

        $display("[TB] counter saturation and clear");
        applyStimulus(0, 0, 0, 2'b10, 1);
        applyStimulus(1, 0, 0, 2'b10, 0);
        repeat (20) applyStimulus(0, 0, 0, 2'b10, 0);
        checkOutput("sat_cnt", bus.cycle_cnt, 15);
        applyStimulus(0, 0, 0, 2'b10, 1);
        applyStimulus(0, 1, 0, 2'b10, 0);
        checkOutput("clr_over_inc_cnt", bus.cycle_cnt, 0);
        applyStimulus(0, 0, 0, 2'b10, 0);

        $display("[TB] reset mid-prescale");
        applyStimulus(0, 0, 0, 2'b01, 0);
        applyStimulus(1, 0, 0, 2'b01, 0);
        repeat (2) applyStimulus(0, 0, 0, 2'b01, 0);
        doReset();
        repeat (6) applyStimulus(0, 0, 0, 2'b01, 0);

        $display("[TB] randomized traffic");
        spd = 2'b01;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) spd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) begin
                nb_valid = 1'($urandom_range(0, 1));
                nb_addr  = 4'($urandom_range(0, 15));
            end
            applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 24) == 0),
                          ($urandom_range(0, 11) == 0), spd, ($urandom_range(0, 49) == 0));
        end
        applyStimulus(0, 1, 0, spd, 0);
        applyStimulus(0, 0, 0, spd, 0);

        @(negedge CLK);
        #1;
        mon_en = 1'b0;
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
